// File: rtl/mmio_if_pkg.sv
// rtl/mmio_if_pkg.sv - shared constants and helpers for the MMIO input-conditioning slice
package mmio_if_pkg;

  // Width of the PIO in_port the conditioner feeds.
  localparam int MMIO_IF_PIO_W = 8;

  // Default debounce length in consecutive differing cycles.
  localparam int MMIO_IF_DB_COUNT_DEF = 16;

  // Default debounce counter width; covers DB_COUNT up to 255.
  localparam int MMIO_IF_CNT_W_DEF = 8;

  // Smallest counter width w with 2**w > db_count.
  function automatic int mmio_if_cnt_w_min(input int db_count);
    int w;
    w = 1;
    while ((1 << w) <= db_count) w++;
    return w;
  endfunction

endpackage

// File: rtl/mmio_if_db_bit.sv
// rtl/mmio_if_db_bit.sv - one-bit synchroniser, debounce counter, stable register and edge pulse (MMIO_IF_IN_COND_BOTH_EDGE_EN)
module mmio_if_db_bit
  import mmio_if_pkg::*;
#(
  parameter int DB_COUNT = MMIO_IF_DB_COUNT_DEF,
  parameter int CNT_W    = MMIO_IF_CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic edge_evt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_COUNT - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  logic             cnt_done;

  assign cnt_done = (cnt == CNT_LAST);

  // Two-flop synchroniser with nothing between the stages.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Count consecutive cycles where the synchronised input disagrees with stable; any agreement restarts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable <= 1'b0;
      cnt    <= '0;
    end else if (s2 == stable) begin
      cnt <= '0;
    end else if (cnt_done) begin
      stable <= s2;
      cnt    <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Pulse on the cycle stable is about to change; rising only unless both edges are enabled.
`ifdef MMIO_IF_IN_COND_BOTH_EDGE_EN
  assign edge_evt = (s2 ^ stable) & cnt_done;
`else
  assign edge_evt = s2 & ~stable & cnt_done;
`endif

endmodule

// File: rtl/mmio_if_in_cond.sv
// rtl/mmio_if_in_cond.sv - conditioned PIO input stage: sync, debounce, sticky events, irq (MMIO_IF_IN_COND_BOTH_EDGE_EN)
module mmio_if_in_cond
  import mmio_if_pkg::*;
#(
  parameter int WIDTH    = MMIO_IF_PIO_W,
  parameter int DB_COUNT = MMIO_IF_DB_COUNT_DEF,
  parameter int CNT_W    = MMIO_IF_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  input  logic             sel,
  input  logic             clr_strobe,
  input  logic [WIDTH-1:0] clr_mask,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] edge_evt;
  logic [WIDTH-1:0] evt;
  logic [WIDTH-1:0] evt_nxt;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    mmio_if_db_bit #(
      .DB_COUNT (DB_COUNT),
      .CNT_W    (CNT_W)
    ) u_db (
      .clk      (clk),
      .reset    (reset),
      .raw      (raw_in[i]),
      .stable   (stable[i]),
      .edge_evt (edge_evt[i])
    );
  end

  // A new edge in the same cycle as its clear keeps the flag set.
  assign evt_nxt = (evt & ~(clr_mask & {WIDTH{clr_strobe}})) | edge_evt;

  // Sticky flags, output mux and irq; irq tracks the next-state flags so it moves with them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      evt      <= '0;
      out_port <= '0;
      irq      <= 1'b0;
    end else begin
      evt      <= evt_nxt;
      out_port <= sel ? evt : stable;
      irq      <= |evt_nxt;
    end
  end

endmodule

// File: tb/tb_mmio_if_in_cond.sv
// tb/tb_mmio_if_in_cond.sv - self-checking bench for mmio_if_in_cond against a sample-window reference model
module tb_mmio_if_in_cond;

  localparam int W  = 8;
  localparam int DB = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] raw_in;
  logic         sel;
  logic         clr_strobe;
  logic [W-1:0] clr_mask;
  logic [W-1:0] out_port;
  logic         irq;

  always #5 clk = ~clk;

  mmio_if_in_cond #(
    .WIDTH    (W),
    .DB_COUNT (DB),
    .CNT_W    (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .raw_in     (raw_in),
    .sel        (sel),
    .clr_strobe (clr_strobe),
    .clr_mask   (clr_mask),
    .out_port   (out_port),
    .irq        (irq)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: a level is accepted once the last DB synchronised samples all disagree with it.
  logic [W-1:0] m_s1, m_s2, m_stable, m_evt, m_out;
  logic         m_irq;
  logic [W-1:0] hist[$];

  function automatic logic [W-1:0] window_flip(input logic [W-1:0] nxt);
    logic [W-1:0] f;
    logic [W-1:0] h;
    for (int i = 0; i < W; i++) begin
      f[i] = (nxt[i] != m_stable[i]);
      if (hist.size() < DB - 1) f[i] = 1'b0;
      for (int j = 0; j < hist.size(); j++) begin
        h = hist[j];
        if (h[i] == m_stable[i]) f[i] = 1'b0;
      end
    end
    return f;
  endfunction

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_stable = '0; m_evt = '0; m_out = '0; m_irq = 1'b0;
    hist.delete();
  endtask

  task automatic model_edge();
    logic [W-1:0] flip, ev, nevt;
    flip = window_flip(m_s2);
`ifdef MMIO_IF_IN_COND_BOTH_EDGE_EN
    ev = flip;
`else
    ev = flip & ~m_stable;
`endif
    nevt     = (m_evt & ~(clr_strobe ? clr_mask : 8'h00)) | ev;
    m_out    = sel ? m_evt : m_stable;
    m_irq    = |nevt;
    m_evt    = nevt;
    m_stable = m_stable ^ flip;
    hist.push_back(m_s2);
    if (hist.size() > DB - 1) void'(hist.pop_front());
    m_s2 = m_s1;
    m_s1 = raw_in;
  endtask

  task automatic cycle();
    if (reset) model_reset();
    else model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic chk8(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_model();
    chk8("out_port_vs_model", out_port, m_out);
    chk1("irq_vs_model", irq, m_irq);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      cycle();
      chk_model();
    end
  endtask

  task automatic clr(input logic [W-1:0] mask);
    clr_strobe = 1'b1;
    clr_mask   = mask;
    cycle();
    chk_model();
    clr_strobe = 1'b0;
    clr_mask   = '0;
  endtask

  logic saw;
  logic found;
  int   guard;

  initial begin
    reset = 1'b1; raw_in = 8'hFF; sel = 1'b0; clr_strobe = 1'b0; clr_mask = '0;
    model_reset();
    #1;
    repeat (3) cycle();
    chk8("reset_out_port", out_port, 8'h00);
    chk1("reset_irq", irq, 1'b0);

    // Release with inputs high: stable on edge DB+2, out_port on edge DB+3.
    reset = 1'b0;
    run(DB + 1);
    chk8("pre_stable_out", out_port, 8'h00);
    chk1("pre_stable_irq", irq, 1'b0);
    cycle();
    chk1("irq_with_stable", irq, 1'b1);
    chk8("out_lags_stable", out_port, 8'h00);
    cycle();
    chk8("out_stable_ff", out_port, 8'hFF);
    sel = 1'b1;
    cycle();
    chk8("out_evt_ff", out_port, 8'hFF);
    clr(8'hFF);
    chk1("irq_clear_all", irq, 1'b0);

    // Debounced fall on every bit.
    raw_in = 8'h00;
    run(DB + 8);
`ifdef MMIO_IF_IN_COND_BOTH_EDGE_EN
    chk1("fall_all_irq", irq, 1'b1);
`else
    chk1("fall_all_irq", irq, 1'b0);
`endif
    clr(8'hFF);
    run(2);

    // Glitch one cycle short of DB is rejected.
    sel = 1'b0; saw = 1'b0; raw_in = 8'h01;
    for (int k = 0; k < DB - 1; k++) begin cycle(); chk_model(); saw |= out_port[0]; end
    raw_in = 8'h00;
    for (int k = 0; k < DB + 8; k++) begin cycle(); chk_model(); saw |= out_port[0]; end
    chk1("pulse15_stable", saw, 1'b0);
    chk1("pulse15_irq", irq, 1'b0);

    // Pulse of exactly DB cycles is accepted.
    saw = 1'b0; raw_in = 8'h01;
    for (int k = 0; k < DB; k++) begin cycle(); chk_model(); saw |= out_port[0]; end
    raw_in = 8'h00;
    for (int k = 0; k < 2 * DB + 8; k++) begin cycle(); chk_model(); saw |= out_port[0]; end
    chk1("pulse16_stable", saw, 1'b1);
    sel = 1'b1;
    cycle(); chk_model();
    chk8("pulse16_evt", out_port, 8'h01);
    chk1("pulse16_irq", irq, 1'b1);
    clr(8'hFF);
    run(2);

    // Masked clear of one flag leaves the other and irq.
    raw_in = 8'h05;
    run(DB + 8);
    chk8("evt_05", out_port, 8'h05);
    clr(8'h01);
    chk1("irq_after_clr01", irq, 1'b1);
    cycle(); chk_model();
    chk8("evt_04", out_port, 8'h04);
    clr(8'h04);
    chk1("irq_after_clr04", irq, 1'b0);
    cycle(); chk_model();
    chk8("evt_00", out_port, 8'h00);

    // Rise on bit 3 coincident with its clear: set wins.
    raw_in = 8'h0D; found = 1'b0; guard = 0;
    while (!found && guard < 4 * DB) begin
      if ((window_flip(m_s2) & ~m_stable & 8'h08) != 8'h00) found = 1'b1;
      else begin cycle(); chk_model(); guard++; end
    end
    if (!found) begin
      n_cmp++; n_fail++;
      $error("FAIL setwins_timeout: observed no rise expected rise within %0d cycles", 4 * DB);
    end else begin
      clr(8'h08);
      chk1("setwins_irq", irq, 1'b1);
      cycle(); chk_model();
      chk8("setwins_evt3", out_port & 8'h08, 8'h08);
    end

    // Debounced fall on bit 2 only.
    clr(8'hFF);
    run(2);
    raw_in = 8'h09;
    run(DB + 8);
`ifdef MMIO_IF_IN_COND_BOTH_EDGE_EN
    chk8("fall_bit2_evt", out_port, 8'h04);
`else
    chk8("fall_bit2_evt", out_port, 8'h00);
`endif

    // Build stable=A0, evt=0A, then toggle sel.
    clr(8'hFF); raw_in = 8'h00; run(DB + 8);
    clr(8'hFF); raw_in = 8'h0A; run(DB + 8);
    raw_in = 8'hA0; run(DB + 8);
    clr(8'hF0); run(1);
    chk8("sel1_start", out_port, 8'h0A);
    for (int t = 0; t < 3; t++) begin
      sel = 1'b0;
      chk8("sel0_before_edge", out_port, 8'h0A);
      cycle(); chk_model();
      chk8("sel0_levels", out_port, 8'hA0);
      sel = 1'b1;
      chk8("sel1_before_edge", out_port, 8'hA0);
      cycle(); chk_model();
      chk8("sel1_events", out_port, 8'h0A);
    end

    // Randomised traffic with one asynchronous reset mid-run.
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 23) == 0) raw_in = 8'($urandom);
      sel        = 1'($urandom_range(0, 1));
      clr_strobe = ($urandom_range(0, 7) == 0);
      clr_mask   = 8'($urandom);
      if (k == 300) begin
        reset = 1'b1;
        #1;
        chk8("async_reset_out", out_port, 8'h00);
        chk1("async_reset_irq", irq, 1'b0);
        cycle();
        reset = 1'b0;
      end
      cycle();
      chk_model();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
